// File: rtl/uart_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the UART blocks.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Oversample tick divider, rounded to nearest, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned ovs);
    longint unsigned den;
    longint unsigned q;
    den = 64'(baud) * 64'(ovs);
    if (den == 0) return 1;
    q = (64'(clk_hz) + den / 2) / den;
    return (q == 0) ? 1 : 32'(q);
  endfunction

  // Bits needed to count 0..v-1, at least 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks; clr restarts the count.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = clog2(DIV);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  // Divider counter with registered tick; held at zero while cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: synchroniser, 3-sample majority vote, framing FSM
// and a valid/ready holding register with overrun indication.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 200_000_000,
  parameter int unsigned BAUD_RATE    = 19200,
  parameter int unsigned FRAME_WIDTH  = 8,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic [0:FRAME_WIDTH-1] dout,
  output logic                   so,
  input  logic                   ro,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int unsigned DIV = calc_div(SYS_CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned M   = OVERSAMPLE / 2;
  localparam int unsigned TW  = clog2(OVERSAMPLE);
  localparam int unsigned BW  = clog2(FRAME_WIDTH);

  logic                   rx_m_q, rx_s_q;
  logic [1:0]             settle_q;
  logic                   armed_q;
  rx_state_e              state_q;
  logic [TW-1:0]          t_q;
  logic [BW-1:0]          bit_q;
  logic                   s0_q, s1_q;
  logic [0:FRAME_WIDTH-1] data_q;
  logic                   perr_q, ferr_q;
  logic [0:FRAME_WIDTH-1] dout_q;
  logic                   so_q, pe_q, fe_q, ov_q;

  logic tick, vote, decide, bit_end, par_exp, done;

  // Tick counter only runs while a character is being framed.
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i  (sys_clk),
    .rst_i  (reset),
    .clr_i  (state_q == ST_IDLE),
    .tick_o (tick)
  );

  assign vote    = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
  assign decide  = tick && (t_q == TW'(M + 1));
  assign bit_end = tick && (t_q == TW'(OVERSAMPLE - 1));
  assign par_exp = (PARITY_MODE == PARITY_ODD) ? ~(^data_q) : ^data_q;
  assign done    = (state_q == ST_STOP) && decide && (bit_q == BW'(STOP_BITS - 1));

  // Two-flop synchroniser; settle_q marks when rx_s carries post-reset line data.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rx_m_q   <= 1'b1;
      rx_s_q   <= 1'b1;
      settle_q <= '0;
    end else begin
      rx_m_q   <= rx;
      rx_s_q   <= rx_m_q;
      settle_q <= {settle_q[0], 1'b1};
    end
  end

  // Framing FSM with in-bit tick counter and vote sample capture.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
      t_q     <= '0;
      bit_q   <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (tick) begin
        if (t_q == TW'(M - 1)) s0_q <= rx_s_q;
        if (t_q == TW'(M))     s1_q <= rx_s_q;
        t_q <= (t_q == TW'(OVERSAMPLE - 1)) ? '0 : t_q + TW'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          t_q    <= '0;
          bit_q  <= '0;
          perr_q <= 1'b0;
          ferr_q <= 1'b0;
          // A start needs a high level seen first, so a stuck-low line is ignored.
          if (armed_q && !rx_s_q) begin
            state_q <= ST_START;
            armed_q <= 1'b0;
          end else if (settle_q[1] && rx_s_q) begin
            armed_q <= 1'b1;
          end
        end
        ST_START: begin
          if (decide && vote)  state_q <= ST_IDLE;
          else if (bit_end)    state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (decide) data_q <= {vote, data_q[0:FRAME_WIDTH-2]};
          if (bit_end) begin
            if (bit_q == BW'(FRAME_WIDTH - 1)) begin
              bit_q   <= '0;
              state_q <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (decide && (vote != par_exp)) perr_q <= 1'b1;
          if (bit_end) state_q <= ST_STOP;
        end
        ST_STOP: begin
          // Leave at the last stop decision so a following start edge is not missed.
          if (decide) begin
            if (!vote) ferr_q <= 1'b1;
            if (bit_q == BW'(STOP_BITS - 1)) state_q <= ST_IDLE;
            else                             bit_q   <= bit_q + BW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Holding register: load when empty or draining, otherwise drop and flag overrun.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      so_q   <= 1'b0;
      pe_q   <= 1'b0;
      fe_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      if (done) begin
        if (!so_q || ro) begin
          dout_q <= data_q;
          pe_q   <= perr_q;
          fe_q   <= ferr_q | ~vote;
          so_q   <= 1'b1;
        end else begin
          ov_q <= 1'b1;
        end
      end else if (so_q && ro) begin
        so_q <= 1'b0;
      end
    end
  end

  assign dout       = dout_q;
  assign so         = so_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: four instances (no parity, even, odd, 9-bit/2-stop)
// driven at 16 clocks per bit, with a negedge monitor recording transfers and pulses.
module tb_uart_rx_ovs;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rx_l;
  logic [3:0]  ro_l;
  wire  [3:0]  so_l, pe_l, fe_l, ov_l;
  wire  [0:7]  dout0, dout1, dout2;
  wire  [0:8]  dout3;

  logic [8:0]  d_l   [4];
  logic [8:0]  cap_d [4];
  logic        cap_pe[4];
  logic        cap_fe[4];
  int          n_xfer[4];
  int          n_so  [4];
  int          n_ov  [4];

  int n_checks = 0;
  int n_fail   = 0;
  int bx, bs, bo;

  always #5 clk = ~clk;

  uart_rx_ovs #(.SYS_CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .FRAME_WIDTH(8),
                .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_p0 (
    .sys_clk(clk), .reset(rst), .rx(rx_l[0]), .dout(dout0), .so(so_l[0]), .ro(ro_l[0]),
    .parity_err(pe_l[0]), .frame_err(fe_l[0]), .overrun(ov_l[0]));

  uart_rx_ovs #(.SYS_CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .FRAME_WIDTH(8),
                .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u_pe (
    .sys_clk(clk), .reset(rst), .rx(rx_l[1]), .dout(dout1), .so(so_l[1]), .ro(ro_l[1]),
    .parity_err(pe_l[1]), .frame_err(fe_l[1]), .overrun(ov_l[1]));

  uart_rx_ovs #(.SYS_CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .FRAME_WIDTH(8),
                .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(1)) u_po (
    .sys_clk(clk), .reset(rst), .rx(rx_l[2]), .dout(dout2), .so(so_l[2]), .ro(ro_l[2]),
    .parity_err(pe_l[2]), .frame_err(fe_l[2]), .overrun(ov_l[2]));

  uart_rx_ovs #(.SYS_CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .FRAME_WIDTH(9),
                .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2)) u_w9 (
    .sys_clk(clk), .reset(rst), .rx(rx_l[3]), .dout(dout3), .so(so_l[3]), .ro(ro_l[3]),
    .parity_err(pe_l[3]), .frame_err(fe_l[3]), .overrun(ov_l[3]));

  assign d_l[0] = 9'(dout0);
  assign d_l[1] = 9'(dout1);
  assign d_l[2] = 9'(dout2);
  assign d_l[3] = 9'(dout3);

  // Record transfers, valid-high cycles and overrun pulses away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (so_l[i] === 1'b1) n_so[i]++;
      if (ov_l[i] === 1'b1) n_ov[i]++;
      if (so_l[i] === 1'b1 && ro_l[i] === 1'b1) begin
        n_xfer[i]++;
        cap_d[i]  = d_l[i];
        cap_pe[i] = pe_l[i];
        cap_fe[i] = fe_l[i];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input int idx, input logic v, input int n);
    rx_l[idx] = v;
    cyc(n);
  endtask

  // One character: start, data LSB first (optional 1-cycle glitch mid-bit), parity, stops.
  task automatic send(input int idx, input logic [8:0] data, input int fw, input int par,
                      input int nstop, input logic stop_v, input int glitch_bit);
    drive(idx, 1'b0, 16);
    for (int i = 0; i < fw; i++) begin
      if (i == glitch_bit) begin
        drive(idx, data[i], 11);
        drive(idx, ~data[i], 1);
        drive(idx, data[i], 4);
      end else begin
        drive(idx, data[i], 16);
      end
    end
    if (par >= 0) drive(idx, par[0], 16);
    for (int i = 0; i < nstop; i++) drive(idx, stop_v, 16);
  endtask

  initial begin
    rst  = 1'b1;
    rx_l = '1;
    ro_l = '1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    cyc(10);

    // Reset state
    check_eq("rst_dout", 32'(d_l[0]), 0);
    check_eq("rst_so",   32'(so_l[0]), 0);
    check_eq("rst_perr", 32'(pe_l[0]), 0);
    check_eq("rst_ferr", 32'(fe_l[0]), 0);
    check_eq("rst_ovr",  32'(ov_l[0]), 0);

    // Plain 8N1 character
    bx = n_xfer[0]; bs = n_so[0]; bo = n_ov[0];
    send(0, 9'h0A5, 8, -1, 1, 1'b1, -1);
    cyc(20);
    check_eq("a5_xfer",  32'(n_xfer[0] - bx), 1);
    check_eq("a5_so_len", 32'(n_so[0] - bs), 1);
    check_eq("a5_dout",  32'(cap_d[0]), 32'hA5);
    check_eq("a5_perr",  32'(cap_pe[0]), 0);
    check_eq("a5_ferr",  32'(cap_fe[0]), 0);
    check_eq("a5_ovr",   32'(n_ov[0] - bo), 0);

    // Even parity: good then bad parity bit
    bx = n_xfer[1];
    send(1, 9'h001, 8, 1, 1, 1'b1, -1);
    cyc(20);
    check_eq("even_ok_dout", 32'(cap_d[1]), 32'h01);
    check_eq("even_ok_perr", 32'(cap_pe[1]), 0);
    send(1, 9'h001, 8, 0, 1, 1'b1, -1);
    cyc(20);
    check_eq("even_bad_perr", 32'(cap_pe[1]), 1);
    check_eq("even_xfer",     32'(n_xfer[1] - bx), 2);

    // Odd parity: good then bad parity bit
    send(2, 9'h001, 8, 0, 1, 1'b1, -1);
    cyc(20);
    check_eq("odd_ok_dout", 32'(cap_d[2]), 32'h01);
    check_eq("odd_ok_perr", 32'(cap_pe[2]), 0);
    send(2, 9'h001, 8, 1, 1, 1'b1, -1);
    cyc(20);
    check_eq("odd_bad_perr", 32'(cap_pe[2]), 1);

    // Bad stop bit with line left low briefly, then recovery
    bx = n_xfer[0];
    send(0, 9'h081, 8, -1, 1, 1'b0, -1);
    drive(0, 1'b0, 10);
    drive(0, 1'b1, 32);
    check_eq("fe_dout", 32'(cap_d[0]), 32'h81);
    check_eq("fe_ferr", 32'(cap_fe[0]), 1);
    send(0, 9'h03C, 8, -1, 1, 1'b1, -1);
    cyc(20);
    check_eq("fe_next_dout", 32'(cap_d[0]), 32'h3C);
    check_eq("fe_next_ferr", 32'(cap_fe[0]), 0);
    check_eq("fe_xfer",      32'(n_xfer[0] - bx), 2);

    // False start then a glitched data bit
    bx = n_xfer[0]; bo = n_ov[0];
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 40);
    check_eq("false_xfer", 32'(n_xfer[0] - bx), 0);
    check_eq("false_so",   32'(so_l[0]), 0);
    check_eq("false_ovr",  32'(n_ov[0] - bo), 0);
    send(0, 9'h05A, 8, -1, 1, 1'b1, 1);
    cyc(20);
    check_eq("glitch_dout", 32'(cap_d[0]), 32'h5A);
    check_eq("glitch_xfer", 32'(n_xfer[0] - bx), 1);

    // Back-to-back characters with consumer stalled
    ro_l[0] = 1'b0;
    bx = n_xfer[0]; bo = n_ov[0];
    send(0, 9'h011, 8, -1, 1, 1'b1, -1);
    send(0, 9'h022, 8, -1, 1, 1'b1, -1);
    cyc(20);
    check_eq("ovr_so",    32'(so_l[0]), 1);
    check_eq("ovr_dout",  32'(d_l[0]), 32'h11);
    check_eq("ovr_pulse", 32'(n_ov[0] - bo), 1);
    ro_l[0] = 1'b1;
    cyc(4);
    check_eq("ovr_xfer",      32'(n_xfer[0] - bx), 1);
    check_eq("ovr_xfer_dout", 32'(cap_d[0]), 32'h11);
    check_eq("ovr_so_drop",   32'(so_l[0]), 0);
    check_eq("ovr_pulse_end", 32'(n_ov[0] - bo), 1);

    // Asynchronous reset in the middle of data bit 3
    bx = n_xfer[0];
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 16);
    drive(0, 1'b1, 16);
    drive(0, 1'b1, 16);
    drive(0, 1'b0, 8);
    #1;
    rst = 1'b1;
    #1;
    check_eq("arst_dout", 32'(d_l[0]), 0);
    check_eq("arst_so",   32'(so_l[0]), 0);
    check_eq("arst_perr_pe", 32'(d_l[1]), 0);
    rx_l[0] = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(48);
    send(0, 9'h0C3, 8, -1, 1, 1'b1, -1);
    cyc(20);
    check_eq("post_rst_dout", 32'(cap_d[0]), 32'hC3);
    check_eq("post_rst_xfer", 32'(n_xfer[0] - bx), 1);

    // 9-bit frame with two stop bits
    bx = n_xfer[3];
    send(3, 9'h1FF, 9, -1, 2, 1'b1, -1);
    cyc(20);
    check_eq("w9_dout", 32'(cap_d[3]), 32'h1FF);
    check_eq("w9_ferr", 32'(cap_fe[3]), 0);
    check_eq("w9_xfer", 32'(n_xfer[3] - bx), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
- Oversampling UART receiver; successor to the single-mode receive path inside the UART IP top.
- Generalised in frame width, oversample ratio, parity mode and stop-bit count.
- Adds majority-vote sampling, false-start rejection, per-character parity/framing error flags and an overrun indication.
- Sits between the rx pin and the receive FIFO; presents characters on the si/ri-style valid/ready pair (so/ro).

Parameters:
- SYS_CLK_FREQ, 200_000_000: system clock frequency in Hz.
- BAUD_RATE, 19200: line rate in bit/s.
- FRAME_WIDTH, 8: data bits per character, legal range 5..9.
- OVERSAMPLE, 16: ticks per bit; even and at least 8.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- sys_clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial line, asynchronous to sys_clk, idle high.
- dout  out  [0:FRAME_WIDTH-1]  received character; dout[FRAME_WIDTH-1] is the LSB, i.e. the first bit on the line.
- so  out  1  dout and flags valid.
- ro  in  1  consumer ready; a transfer happens on a cycle with so=1 and ro=1.
- parity_err  out  1  parity mismatch for the held character; 0 when PARITY_MODE=0.
- frame_err  out  1  some stop bit sampled 0 for the held character.
- overrun  out  1  one-cycle pulse when a completed character is dropped.

Behaviour:
- Clock and reset: one clock (sys_clk); reset is asynchronous and active-high.
- Reset values: dout=0, so=0, parity_err=0, frame_err=0, overrun=0, FSM=IDLE, synchroniser flops=1.
  - Reset mid-character discards the partial character.
- Synchroniser: rx passes through 2 flops (rx_s). All logic uses rx_s only.
- Tick generator:
  - DIV = SYS_CLK_FREQ/(BAUD_RATE*OVERSAMPLE), rounded to nearest, minimum 1.
  - Emits a one-cycle tick every DIV cycles.
  - Its counter clears when the FSM leaves IDLE, so the first tick occurs DIV cycles after start detection.
- Bit timing: tick counter t runs 0..OVERSAMPLE-1 within each bit. rx_s is sampled at t = M-1, M, M+1, where M = OVERSAMPLE/2.
- Bit decision: majority of the 3 samples, taken at t = M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s=0 (previous rx_s=1, or line low after reset release counts as no edge) -> START.
  - START: at decision, voted 1 -> IDLE (false start, no output); voted 0 -> wait to t=OVERSAMPLE-1, then DATA.
  - DATA: shift FRAME_WIDTH bits, LSB first, so dout[FRAME_WIDTH-1] holds the first bit. After the last bit -> PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: expected bit = XOR of data bits for even, XNOR for odd. Mismatch sets the internal perr.
  - STOP: vote each of STOP_BITS bits; any 0 sets the internal ferr.
    - Returns to IDLE directly at the decision point of the last stop bit (half-bit early), so back-to-back characters are caught.
    - On that same cycle the character completes.
- Completion (cycle C); holding register updates at C+1:
  - so=0, or so=1 with ro=1 at C: load dout, parity_err, frame_err; so=1 at C+1.
  - so=1 with ro=0 at C: new character is discarded; holding register unchanged; overrun=1 for exactly cycle C+1.
- Handshake: so stays 1, and dout/flags stay stable, until the so&ro cycle.
  - so drops the cycle after the transfer unless a completion coincides with it.
  - so never deasserts without a transfer, except on reset.
- Framing error does not resynchronise. If the line stays low after a bad stop bit, no new START is taken until rx_s has been seen high.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/EVEN/ODD constants.
  - FSM state encodings.
  - Constant function computing DIV.
  - clog2 function for the tick and bit counter widths.
- Sub-module uart_baud_tick: parametrised divider with a sync clear input and a tick output.
  - Reused later by the parametrised transmitter.
- Synchroniser, voting, FSM and holding register stay in uart_rx_ovs.

Test Plan:
Bench parameters unless noted: SYS_CLK_FREQ=16_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=16, so DIV=1 and a bit lasts 16 cycles.
- PARITY_MODE=0, ro=1, send 0xA5, 1 stop bit -> so pulses 1 cycle; dout=8'hA5; parity_err=0, frame_err=0, overrun never 1.
- PARITY_MODE=1, send 0x01 with parity bit 1 -> dout=0x01, parity_err=0. Then 0x01 with parity bit 0 -> parity_err=1. PARITY_MODE=2 with 0x01 and parity bit 0 -> parity_err=0.
- Stop bit driven 0, then line high for 2 bits, then 0x3C -> first character frame_err=1; 0x3C received with frame_err=0.
- rx low for 4 cycles, then high -> no so and no overrun; FSM returns to IDLE. A data bit with a 1-cycle glitch at t=M -> bit value unchanged (0x5A received intact).
- ro=0, send 0x11 then 0x22 back-to-back -> so=1 holding 0x11; overrun pulses once at 0x22 completion. Raise ro -> 0x11 transferred, then so=0 (0x22 lost).
- Assert reset during data bit 3 of 0x77 -> all outputs 0 asynchronously. After release and line idle, 0xC3 is received correctly. Also run FRAME_WIDTH=9 with STOP_BITS=2 on 9'h1FF -> dout=9'h1FF.
